// File: rtl/circuit_fn.sv
// Registered 3-input truth-table function with rising-edge pulse and saturating hit counter.
// Optional macro CIRCUIT_FN_INPUT_SYNC_EN adds a 2-flop synchronizer on x1/x2/x3.
module circuit_fn #(
    parameter logic [7:0] TRUTH_TABLE = 8'hE8,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x1,
    input  logic             x2,
    input  logic             x3,
    input  logic             clr_count,
    output logic             z,
    output logic             z_rise,
    output logic [CNT_W-1:0] hit_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]       eval_idx;
    logic             f;
    logic             z_d, z_q;
    logic             z_rise_d, z_rise_q;
    logic [CNT_W-1:0] hit_count_d, hit_count_q;

`ifdef CIRCUIT_FN_INPUT_SYNC_EN
    // Each input bit passes through two flops before it reaches the function.
    logic [2:0] sync1_d, sync1_q;
    logic [2:0] sync2_d, sync2_q;

    always_comb begin
        sync1_d = {x1, x2, x3};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign eval_idx = sync2_q;
`else
    assign eval_idx = {x1, x2, x3};
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        f           = TRUTH_TABLE[eval_idx];
        z_d         = f;
        z_rise_d    = f & ~z_q;
        hit_count_d = hit_count_q;
        if (clr_count) begin
            hit_count_d = '0;
        end else if (f && (hit_count_q != CNT_MAX)) begin
            hit_count_d = hit_count_q + CNT_ONE;
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q         <= 1'b0;
            z_rise_q    <= 1'b0;
            hit_count_q <= '0;
        end else begin
            z_q         <= z_d;
            z_rise_q    <= z_rise_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign z         = z_q;
    assign z_rise    = z_rise_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_circuit_fn.sv
// Self-checking bench for circuit_fn: three instances (majority, 4-bit counter, XOR table)
// compared every cycle against a behavioural model, plus directed scenario checks.
module tb_circuit_fn;

`ifdef CIRCUIT_FN_INPUT_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif
    localparam int LAT = SYNC ? 3 : 1;

    logic clk = 1'b0;
    logic rst, x1, x2, x3, clr_count;

    logic        z0, r0;
    logic [15:0] c0;
    logic        z1, r1;
    logic [3:0]  c1;
    logic        z2, r2;
    logic [15:0] c2;

    always #5 clk = ~clk;

    circuit_fn u_maj (
        .clk(clk), .rst(rst), .x1(x1), .x2(x2), .x3(x3), .clr_count(clr_count),
        .z(z0), .z_rise(r0), .hit_count(c0)
    );

    circuit_fn #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .x1(x1), .x2(x2), .x3(x3), .clr_count(clr_count),
        .z(z1), .z_rise(r1), .hit_count(c1)
    );

    circuit_fn #(.TRUTH_TABLE(8'h96)) u_xor (
        .clk(clk), .rst(rst), .x1(x1), .x2(x2), .x3(x3), .clr_count(clr_count),
        .z(z2), .z_rise(r2), .hit_count(c2)
    );

    int compared   = 0;
    int mismatched = 0;
    int rise_seen  = 0;

    // Behavioural model state, one slot per instance.
    bit [7:0] tt [3] = '{8'hE8, 8'hE8, 8'h96};
    int       mx [3] = '{65535, 15, 65535};
    bit       m_z [3];
    bit       m_r [3];
    int       m_c [3];
    bit [2:0] hist [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies one clock edge of the specified behaviour to the model.
    task automatic model_edge(input bit r, input bit c, input bit [2:0] idx);
        bit [2:0] ev;
        bit       nz;
        ev = SYNC ? hist[1] : idx;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_z[k] = 1'b0;
                m_r[k] = 1'b0;
                m_c[k] = 0;
            end else begin
                nz     = tt[k][ev];
                m_r[k] = nz && !m_z[k];
                m_z[k] = nz;
                if (c)                      m_c[k] = 0;
                else if (nz && m_c[k] < mx[k]) m_c[k] = m_c[k] + 1;
            end
        end
        if (r) begin
            hist[0] = 3'b000;
            hist[1] = 3'b000;
        end else begin
            hist[1] = hist[0];
            hist[0] = idx;
        end
    endtask

    task automatic compare_all();
        check("maj_z",     32'(z0), 32'(m_z[0]));
        check("maj_rise",  32'(r0), 32'(m_r[0]));
        check("maj_count", 32'(c0), 32'(m_c[0]));
        check("sat_z",     32'(z1), 32'(m_z[1]));
        check("sat_rise",  32'(r1), 32'(m_r[1]));
        check("sat_count", 32'(c1), 32'(m_c[1]));
        check("xor_z",     32'(z2), 32'(m_z[2]));
        check("xor_rise",  32'(r2), 32'(m_r[2]));
        check("xor_count", 32'(c2), 32'(m_c[2]));
    endtask

    // Drive one cycle of stimulus (called just after a falling edge), then check.
    task automatic step(input bit [2:0] idx, input bit c, input bit r);
        {x1, x2, x3} = idx;
        clr_count    = c;
        rst          = r;
        @(posedge clk);
        model_edge(r, c, idx);
        @(negedge clk);
        if (r0) rise_seen++;
        compare_all();
    endtask

    initial begin
        bit [7:0] maj_exp;
        bit [7:0] xor_exp;
        int       base;
        maj_exp = 8'b1110_1000;
        xor_exp = 8'b1001_0110;
        rst = 1'b1; clr_count = 1'b0; {x1, x2, x3} = 3'b000;
        @(negedge clk);

        // Reset state
        step(3'b111, 1'b0, 1'b1);
        step(3'b111, 1'b0, 1'b1);
        check("reset_z",     32'(z0), 32'd0);
        check("reset_count", 32'(c0), 32'd0);

        // Exhaustive sweep, each index held for the pipeline latency
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < LAT; j++) step(3'(i), 1'b0, 1'b0);
            check("sweep_maj", 32'(z0), 32'(maj_exp[i]));
            check("sweep_xor", 32'(z2), 32'(xor_exp[i]));
        end

        // Edge pulse: 000 flushed with counter cleared, then 011 for 5 cycles
        for (int j = 0; j < LAT + 1; j++) step(3'b000, 1'b1, 1'b0);
        rise_seen = 0;
        for (int j = 0; j < 5; j++) step(3'b011, 1'b0, 1'b0);
        for (int j = 0; j < LAT + 1; j++) step(3'b000, 1'b0, 1'b0);
        check("edge_rise_count", 32'(rise_seen), 32'd1);
        check("edge_hit_count",  32'(c0), 32'd5);

        // Saturation of the 4-bit counter
        step(3'b000, 1'b1, 1'b0);
        for (int j = 0; j < 20 + LAT; j++) step(3'b111, 1'b0, 1'b0);
        check("sat_stop", 32'(c1), 32'd15);
        check("sat_wide", 32'(c0) > 32'd15 ? 32'd1 : 32'd0, 32'd1);

        // Clear priority with z held at 1
        for (int j = 0; j < LAT + 1; j++) step(3'b111, 1'b1, 1'b0);
        for (int j = 0; j < 7; j++) step(3'b111, 1'b0, 1'b0);
        check("clr_pre",   32'(c0), 32'd7);
        step(3'b111, 1'b1, 1'b0);
        check("clr_zero",  32'(c0), 32'd0);
        check("clr_z",     32'(z0), 32'd1);
        step(3'b111, 1'b0, 1'b0);
        check("clr_incr",  32'(c0), 32'd1);

        // Reset mid-run
        step(3'b111, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) step(3'b111, 1'b0, 1'b0);
        check("rst_pre", 32'(c0), 32'd3);
        step(3'b111, 1'b0, 1'b1);
        check("rst_z",     32'(z0), 32'd0);
        check("rst_rise",  32'(r0), 32'd0);
        check("rst_count", 32'(c0), 32'd0);
        for (int j = 0; j < LAT - 1; j++) begin
            step(3'b111, 1'b0, 1'b0);
            check("rst_z_hold", 32'(z0), 32'd0);
        end
        step(3'b111, 1'b0, 1'b0);
        check("rst_z_back",  32'(z0), 32'd1);
        check("rst_rise_back", 32'(r0), 32'd1);

        // Randomized traffic against the model
        base = compared;
        for (int j = 0; j < 400; j++) begin
            step(3'($urandom_range(0, 7)),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 49) == 0));
        end
        check("random_ran", 32'(compared - base), 32'd3600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/circuit_fn.md
CIRCUIT_FN -- requirements
Module: circuit_fn

Interface
REQ-001 SHALL provide parameter TRUTH_TABLE, default 8'hE8, meaning z value for each input index {x1,x2,x3} (bit 0 = 000 ... bit 7 = 111; default = 3-input majority).
REQ-002 SHALL provide parameter CNT_W, default 16, meaning width of hit_count.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port: x1  input  1  function input, MSB of index.
REQ-007 SHALL have port: x2  input  1  function input, middle bit of index.
REQ-008 SHALL have port: x3  input  1  function input, LSB of index.
REQ-009 SHALL have port: clr_count  input  1  synchronous clear of hit_count.
REQ-010 SHALL have port: z  output  1  registered function result.
REQ-011 SHALL have port: z_rise  output  1  one-cycle pulse on z 0->1 transition.
REQ-012 SHALL have port: hit_count  output  CNT_W  saturating count of cycles with z=1.

Function
REQ-013 SHALL compute f = TRUTH_TABLE[{x1,x2,x3}] combinationally from the sampled inputs.
REQ-014 SHALL register f into z on each rising clk edge; latency from input change to z is 1 cycle (macro off).
REQ-015 SHALL assert z_rise for exactly one cycle, in the same cycle z first reads 1 after reading 0; no pulse while z stays 1.
REQ-016 SHALL increment hit_count by 1 on each clock edge where the newly registered z is 1.
REQ-017 SHALL saturate hit_count at all-ones; no wrap-around to 0.
REQ-018 SHALL give clr_count priority over increment: clr_count=1 loads hit_count to 0 regardless of z.
REQ-019 SHALL be free of latches and of combinational paths from any input to any output.

Reset
REQ-020 SHALL, while rst=1 at a clock edge, load z=0, z_rise=0, hit_count=0, and all synchronizer stages=0.
REQ-021 SHALL give rst priority over clr_count and over function evaluation; reset mid-operation discards in-flight samples.
REQ-022 SHALL produce the first valid z one cycle (macro off) or three cycles (macro on) after rst deasserts; z_rise may not fire on the first post-reset result unless that result is 1.

Configuration
REQ-023 SHALL honour macro CIRCUIT_FN_INPUT_SYNC_EN: when defined, x1/x2/x3 each pass through a 2-flop synchronizer before evaluation, making input-to-z latency 3 cycles; when undefined, inputs feed the function directly, latency 1 cycle.
REQ-024 SHALL keep all other behaviour (z_rise, hit_count, reset values) identical with or without the macro, apart from the added latency.

Verification
REQ-025 SHALL cover exhaustive sweep: apply {x1,x2,x3}=000..111, 10 ns each -> z after latency = 0,0,0,1,0,1,1,1 (default table).
REQ-026 SHALL cover edge pulse: inputs 000 then 011 held 5 cycles -> z_rise=1 for exactly one cycle, hit_count=5.
REQ-027 SHALL cover saturation: CNT_W=4, inputs 111 held 20 cycles -> hit_count stops at 15.
REQ-028 SHALL cover clear priority: hit_count=7, clr_count=1 with inputs 111 -> hit_count=0 next cycle, then increments to 1.
REQ-029 SHALL cover reset mid-run: inputs 111, hit_count=3, rst=1 one cycle -> z=0, z_rise=0, hit_count=0; z returns to 1 after the configured latency.
REQ-030 SHALL cover custom table: TRUTH_TABLE=8'h96 (3-input XOR), sweep 000..111 -> z = 0,1,1,0,1,0,0,1.
